// File: rtl/vga_scanout.sv
// VGA scanout: raster counters, incremental image-memory fetch and a latency-matched
// sync/pixel pipeline. The stored image sits at the top-left corner and everything else is black.
module vga_scanout #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int IMG_BASE0 = 0,
  parameter int IMG_BASE1 = 65536,
  parameter int ADDR_W    = 17,
  parameter int MEM_LAT   = 2
) (
  input  logic              gpu_clk,
  input  logic              reset,
  input  logic              image_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic [23:0]       rgb_out,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG      = HW'(IMG_W);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG      = VW'(IMG_H);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] BASE0  = ADDR_W'(IMG_BASE0);
  localparam logic [ADDR_W-1:0] BASE1  = ADDR_W'(IMG_BASE1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic in_img;
    logic frame;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

  logic [HW-1:0]        h_cnt_q, h_cnt_d;
  logic [VW-1:0]        v_cnt_q, v_cnt_d;
  logic                 sel_meta_q, sel_meta_d;
  logic                 sel_sync_q, sel_sync_d;
  logic                 sel_q, sel_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  stage_t [MEM_LAT:0]   dly_q, dly_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic [23:0]          rgb_q, rgb_d;
  logic                 frame_start_q, frame_start_d;

  stage_t               st0;
  logic [ADDR_W-1:0]    cur_addr;

  always_comb begin
    // NOTE: every _d gets its default first, so no branch can leave one unassigned and infer a latch.
    h_cnt_d       = h_cnt_q + 1'b1;
    v_cnt_d       = v_cnt_q;
    sel_meta_d    = image_select;
    sel_sync_d    = sel_meta_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    mem_addr_d    = mem_addr_q;

    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      // Select only moves at the frame boundary, so a frame never mixes two images.
      if (v_cnt_q == V_LAST) sel_d = sel_sync_q;
    end

    st0.active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    st0.in_img = (h_cnt_q < H_IMG) && (v_cnt_q < V_IMG);
    st0.hs     = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
    st0.vs     = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
    st0.frame  = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Raster-order walk of the image: reload base at (0,0), else bump per fetched pixel.
    cur_addr    = st0.frame ? (sel_q ? BASE1 : BASE0) : ptr_q;
    mem_rd_en_d = st0.in_img;
    if (st0.in_img) begin
      mem_addr_d = cur_addr;
      ptr_d      = cur_addr + 1'b1;
    end

    // Timing flags ride alongside the memory fetch so they emerge with the matching data.
    dly_d         = {dly_q[MEM_LAT-1:0], st0};
    hsync_d       = dly_q[MEM_LAT].hs;
    vsync_d       = dly_q[MEM_LAT].vs;
    frame_start_d = dly_q[MEM_LAT].frame;
    rgb_d         = (dly_q[MEM_LAT].active && dly_q[MEM_LAT].in_img) ? {3{mem_data}} : 24'h0;
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge gpu_clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      sel_meta_q    <= 1'b0;
      sel_sync_q    <= 1'b0;
      sel_q         <= 1'b0;
      ptr_q         <= '0;
      mem_addr_q    <= '0;
      mem_rd_en_q   <= 1'b0;
      // NOTE: the delay line is reset too, so no stale sync pulse or pixel leaks out after reset.
      dly_q         <= {(MEM_LAT + 1){STAGE_IDLE}};
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      sel_meta_q    <= sel_meta_d;
      sel_sync_q    <= sel_sync_d;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      dly_q         <= dly_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;
  assign frame_start = frame_start_q;

endmodule
